// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one txuart transmitter between two byte sources:
//   - Port A: echo path straight from rxuart. It has no backpressure, so it
//     is buffered in a 2^LGFLEN-entry FIFO. Bytes arriving while the FIFO is
//     full (and not being read that cycle) are dropped and flagged.
//   - Port B: local message source with a one-byte holding register and a
//     busy handshake.
// A two-state FSM (IDLE/SEND) picks the next byte, presents it on o_tx_stb /
// o_tx_data and holds it until txuart takes it (o_tx_stb && !i_tx_busy).
//
// Configuration macro:
//   UART_TX_ARB_RR_EN  defined   -> round-robin between A and B on ties
//                      undefined -> fixed priority, A always wins
//
// Parameters:
//   LGFLEN        log2 of the port-A FIFO depth (legal range 1..8)
//
// Ports:
//   i_clk         system clock, rising edge
//   i_reset_n     asynchronous active-low reset
//   i_a_stb       port A byte strobe (one cycle, from rxuart)
//   i_a_data      port A byte
//   i_b_stb       port B request, held until accepted
//   i_b_data      port B byte
//   o_b_busy      port B holding register full
//   i_ovf_clr     clears o_a_overflow
//   o_a_overflow  sticky: a port A byte was dropped
//   o_a_fill      port A FIFO occupancy
//   o_tx_stb      byte request to txuart
//   o_tx_data     byte to txuart, stable while o_tx_stb is high
//   i_tx_busy     txuart busy
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int LGFLEN = 4
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_a_stb,
  input  logic [7:0]      i_a_data,
  input  logic            i_b_stb,
  input  logic [7:0]      i_b_data,
  output logic            o_b_busy,
  input  logic            i_ovf_clr,
  output logic            o_a_overflow,
  output logic [LGFLEN:0] o_a_fill,
  output logic            o_tx_stb,
  output logic [7:0]      o_tx_data,
  input  logic            i_tx_busy
);

  localparam int DEPTH = 1 << LGFLEN;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]      state;

  logic [7:0]      fifo_mem [DEPTH];
  logic [LGFLEN:0] wr_ptr;
  logic [LGFLEN:0] rd_ptr;
  logic            a_empty;
  logic            a_full;
  logic            a_push;
  logic            a_pop;
  logic            a_drop;
  logic [7:0]      a_head;

  logic [7:0]      b_hold;
  logic            b_full;
  logic            b_accept;

  logic            grant_a;
  logic            grant_b;
  logic            tx_taken;

  // Pointers carry one extra wrap bit: equal means empty, differing only in
  // the MSB means full.
  assign a_empty = (wr_ptr == rd_ptr);
  assign a_full  = (wr_ptr == {~rd_ptr[LGFLEN], rd_ptr[LGFLEN-1:0]});
  assign a_head  = fifo_mem[rd_ptr[LGFLEN-1:0]];

  assign b_accept = i_b_stb && !b_full;
  assign tx_taken = (state == SEND) && !i_tx_busy;

`ifdef UART_TX_ARB_RR_EN
  // last_b remembers whether the most recent grant went to B; on a tie the
  // other source wins. Reset to "B last" so A takes the first tie.
  logic last_b;

  assign grant_a = (state == IDLE) && !a_empty && (!b_full || last_b);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_b <= 1'b1;
    end else if (grant_a || grant_b) begin
      last_b <= grant_b;
    end
  end
`else
  assign grant_a = (state == IDLE) && !a_empty;
`endif

  assign grant_b = (state == IDLE) && b_full && !grant_a;

  // A pop frees a slot in the same cycle, so a strobe on a full FIFO is
  // still accepted when the head is being granted.
  assign a_pop  = grant_a;
  assign a_push = i_a_stb && (!a_full || a_pop);
  assign a_drop = i_a_stb && a_full && !a_pop;

  // FIFO storage has no reset; validity is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (a_push) begin
      fifo_mem[wr_ptr[LGFLEN-1:0]] <= i_a_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (a_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (a_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A fresh drop takes precedence over a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_a_overflow <= 1'b0;
    end else if (a_drop) begin
      o_a_overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      o_a_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      b_full <= 1'b0;
      b_hold <= 8'h00;
    end else if (b_accept) begin
      b_full <= 1'b1;
      b_hold <= i_b_data;
    end else if (grant_b) begin
      b_full <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      o_tx_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a) begin
            o_tx_data <= a_head;
            state     <= SEND;
          end else if (grant_b) begin
            o_tx_data <= b_hold;
            state     <= SEND;
          end
        end
        SEND: begin
          if (tx_taken) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_tx_stb = (state == SEND);
  assign o_b_busy = b_full;
  assign o_a_fill = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (LGFLEN = 4). A queue-based model of the
// two sources and the transmitter handshake runs alongside the DUT; every
// cycle the DUT outputs are compared with it. Delivered byte sequences of
// both DUT and model are also compared with hand-written expected lists.
// Honours UART_TX_ARB_RR_EN for the arbitration expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int LGFLEN = 4;
  localparam int DEPTH  = 1 << LGFLEN;

  logic            i_clk = 1'b0;
  logic            i_reset_n = 1'b0;
  logic            i_a_stb = 1'b0;
  logic [7:0]      i_a_data = 8'h00;
  logic            i_b_stb = 1'b0;
  logic [7:0]      i_b_data = 8'h00;
  logic            o_b_busy;
  logic            i_ovf_clr = 1'b0;
  logic            o_a_overflow;
  logic [LGFLEN:0] o_a_fill;
  logic            o_tx_stb;
  logic [7:0]      o_tx_data;
  logic            i_tx_busy = 1'b0;

  int num_checks = 0;
  int num_errors = 0;

  // model state
  logic [7:0] m_q[$];
  logic       m_b_valid = 1'b0;
  logic [7:0] m_b_byte = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_stb = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_last_b = 1'b1;

  // delivered-byte logs and the expected list for the current scenario
  logic [7:0] m_log[$];
  logic [7:0] dut_log[$];
  logic [7:0] exp_log[$];

  logic       prev_stb = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_tx_arbiter #(.LGFLEN(LGFLEN)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_a_stb      (i_a_stb),
    .i_a_data     (i_a_data),
    .i_b_stb      (i_b_stb),
    .i_b_data     (i_b_data),
    .o_b_busy     (o_b_busy),
    .i_ovf_clr    (i_ovf_clr),
    .o_a_overflow (o_a_overflow),
    .o_a_fill     (o_a_fill),
    .o_tx_stb     (o_tx_stb),
    .o_tx_data    (o_tx_data),
    .i_tx_busy    (i_tx_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus: drive on the falling edge, return just after the
  // following rising edge once the per-cycle compare has run.
  task automatic apply_stimulus(input logic a_stb, input logic [7:0] a_data,
                                input logic b_stb, input logic [7:0] b_data,
                                input logic busy, input logic clr);
    @(negedge i_clk);
    i_a_stb   = a_stb;
    i_a_data  = a_data;
    i_b_stb   = b_stb;
    i_b_data  = b_data;
    i_tx_busy = busy;
    i_ovf_clr = clr;
    @(posedge i_clk);
    #2;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset_n = 1'b0;
    i_a_stb   = 1'b0;
    i_b_stb   = 1'b0;
    i_tx_busy = 1'b0;
    i_ovf_clr = 1'b0;
    #1;
    check_output("rst_tx_stb", {31'd0, o_tx_stb}, 32'd0);
    check_output("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
    check_output("rst_b_busy", {31'd0, o_b_busy}, 32'd0);
    check_output("rst_overflow", {31'd0, o_a_overflow}, 32'd0);
    check_output("rst_fill", {27'd0, o_a_fill}, 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #2;
    check_output("rel_fill", {27'd0, o_a_fill}, 32'd0);
    check_output("rel_b_busy", {31'd0, o_b_busy}, 32'd0);
  endtask

  task automatic clear_logs();
    m_log.delete();
    dut_log.delete();
    exp_log.delete();
  endtask

  task automatic check_logs(input string name);
    check_output({name, "_dut_len"}, dut_log.size(), exp_log.size());
    check_output({name, "_model_len"}, m_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < dut_log.size()) check_output({name, "_dut_byte"}, {24'd0, dut_log[i]}, {24'd0, exp_log[i]});
      if (i < m_log.size()) check_output({name, "_model_byte"}, {24'd0, m_log[i]}, {24'd0, exp_log[i]});
    end
  endtask

  // Model step and per-cycle compare.
  always @(posedge i_clk) begin : cmp_proc
    logic dropped;
    logic b_was_full;
    logic pick_a;
    logic a_turn;
    if (!i_reset_n) begin
      m_q.delete();
      m_b_valid = 1'b0;
      m_b_byte  = 8'h00;
      m_ovf     = 1'b0;
      m_stb     = 1'b0;
      m_data    = 8'h00;
      m_last_b  = 1'b1;
    end else begin
      if (prev_stb && !i_tx_busy) dut_log.push_back(prev_data);
      b_was_full = m_b_valid;
`ifdef UART_TX_ARB_RR_EN
      a_turn = m_last_b;
`else
      a_turn = 1'b1;
`endif
      if (m_stb) begin
        if (!i_tx_busy) begin
          m_log.push_back(m_data);
          m_stb = 1'b0;
        end
      end else if (m_q.size() != 0 || m_b_valid) begin
        pick_a = (m_q.size() != 0) && (!m_b_valid || a_turn);
        if (pick_a) begin
          m_data = m_q.pop_front();
        end else begin
          m_data    = m_b_byte;
          m_b_valid = 1'b0;
        end
        m_last_b = !pick_a;
        m_stb    = 1'b1;
      end
      dropped = 1'b0;
      if (i_a_stb) begin
        if (m_q.size() < DEPTH) m_q.push_back(i_a_data);
        else begin
          dropped = 1'b1;
          m_ovf   = 1'b1;
        end
      end
      if (i_ovf_clr && !dropped) m_ovf = 1'b0;
      if (i_b_stb && !b_was_full) begin
        m_b_valid = 1'b1;
        m_b_byte  = i_b_data;
      end
    end
    #1;
    check_output("cyc_tx_stb", {31'd0, o_tx_stb}, {31'd0, m_stb});
    if (m_stb) check_output("cyc_tx_data", {24'd0, o_tx_data}, {24'd0, m_data});
    check_output("cyc_b_busy", {31'd0, o_b_busy}, {31'd0, m_b_valid});
    check_output("cyc_fill", {27'd0, o_a_fill}, m_q.size());
    check_output("cyc_overflow", {31'd0, o_a_overflow}, {31'd0, m_ovf});
    prev_stb  = o_tx_stb;
    prev_data = o_tx_data;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int stable_cnt;
    $display("[TB] start");
    @(negedge i_clk);
    @(negedge i_clk);
    check_output("init_tx_stb", {31'd0, o_tx_stb}, 32'd0);
    check_output("init_fill", {27'd0, o_a_fill}, 32'd0);
    check_output("init_b_busy", {31'd0, o_b_busy}, 32'd0);
    i_reset_n = 1'b1;
    idle_cycles(2);

    // A latency: strobe at n, fill 1 at n+1, stb with 55 at n+2 for one cycle
    clear_logs();
    apply_stimulus(1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0);
    check_output("alat_fill_n1", {27'd0, o_a_fill}, 32'd1);
    check_output("alat_stb_n1", {31'd0, o_tx_stb}, 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    check_output("alat_stb_n2", {31'd0, o_tx_stb}, 32'd1);
    check_output("alat_data_n2", {24'd0, o_tx_data}, 32'h55);
    check_output("alat_fill_n2", {27'd0, o_a_fill}, 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    check_output("alat_stb_n3", {31'd0, o_tx_stb}, 32'd0);
    exp_log.push_back(8'h55);
    check_logs("alat");

    // B latency plus reset mid-SEND with 41 on the bus
    apply_stimulus(1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    check_output("rst_pre_stb", {31'd0, o_tx_stb}, 32'd1);
    check_output("rst_pre_data", {24'd0, o_tx_data}, 32'h41);
    apply_stimulus(1'b0, 8'h00, 1'b1, 8'hB2, 1'b1, 1'b0);
    check_output("rst_pre_b_busy", {31'd0, o_b_busy}, 32'd1);
    do_reset();
    idle_cycles(2);

    // FIFO overflow: transmitter held by C3, 17 A bytes, 10 dropped
    clear_logs();
    apply_stimulus(1'b0, 8'h00, 1'b1, 8'hC3, 1'b1, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    check_output("ovf_b_busy_drop", {31'd0, o_b_busy}, 32'd0);
    for (int i = 0; i <= 16; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 8'h00, 1'b1, 1'b0);
    check_output("ovf_fill", {27'd0, o_a_fill}, 32'd16);
    check_output("ovf_flag", {31'd0, o_a_overflow}, 32'd1);
    idle_cycles(40);
    exp_log.push_back(8'hC3);
    for (int i = 0; i < 16; i++) exp_log.push_back(8'(i));
    check_logs("ovf");
    check_output("ovf_flag_sticky", {31'd0, o_a_overflow}, 32'd1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    check_output("ovf_clr", {31'd0, o_a_overflow}, 32'd0);

    // Full FIFO with a write on the pop cycle
    clear_logs();
    apply_stimulus(1'b1, 8'h20, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int j = 1; j <= 16; j++) apply_stimulus(1'b1, 8'(8'h20 + j), 1'b0, 8'h00, 1'b1, 1'b0);
    check_output("full_fill", {27'd0, o_a_fill}, 32'd16);
    check_output("full_no_ovf", {31'd0, o_a_overflow}, 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    check_output("full_idle_stb", {31'd0, o_tx_stb}, 32'd0);
    apply_stimulus(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0);
    check_output("full_rw_fill", {27'd0, o_a_fill}, 32'd16);
    check_output("full_rw_ovf", {31'd0, o_a_overflow}, 32'd0);
    check_output("full_rw_data", {24'd0, o_tx_data}, 32'h21);
    idle_cycles(40);
    exp_log.push_back(8'h20);
    for (int j = 1; j <= 16; j++) exp_log.push_back(8'(8'h20 + j));
    exp_log.push_back(8'hAA);
    check_logs("full");

    // Arbitration: A holds 01,02 and B holds B0 behind a B filler F0
    do_reset();
    clear_logs();
    apply_stimulus(1'b0, 8'h00, 1'b1, 8'hF0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    apply_stimulus(1'b1, 8'h02, 1'b1, 8'hB0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    check_output("arb_fill", {27'd0, o_a_fill}, 32'd2);
    check_output("arb_b_busy", {31'd0, o_b_busy}, 32'd1);
    idle_cycles(12);
    exp_log.push_back(8'hF0);
    exp_log.push_back(8'h01);
`ifdef UART_TX_ARB_RR_EN
    exp_log.push_back(8'hB0);
    exp_log.push_back(8'h02);
`else
    exp_log.push_back(8'h02);
    exp_log.push_back(8'hB0);
`endif
    check_logs("arb");

    // Hold under busy for 100 cycles
    clear_logs();
    stable_cnt = 0;
    apply_stimulus(1'b0, 8'h00, 1'b1, 8'h7E, 1'b1, 1'b0);
    check_output("hold_b_busy", {31'd0, o_b_busy}, 32'd1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    check_output("hold_b_busy_drop", {31'd0, o_b_busy}, 32'd0);
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      if (o_tx_stb === 1'b1 && o_tx_data === 8'h7E) stable_cnt++;
    end
    check_output("hold_stable", stable_cnt, 32'd100);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    check_output("hold_taken", {31'd0, o_tx_stb}, 32'd0);
    idle_cycles(2);
    exp_log.push_back(8'h7E);
    check_logs("hold");

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `txuart` transmitter between two byte sources.
- Port A is the echo path. It is driven straight from the `rxuart` strobe/data outputs, has no backpressure, and so is buffered in a FIFO.
- Port B is a local message source (status/banner text) with a busy handshake.

The block sits between `rxuart`, the local source and `txuart`, replacing the direct rx-to-tx strobe wiring used by the smart echo test. It decides which byte `txuart` sends next and holds `o_tx_stb` until `txuart` takes the byte.

## Interface
- `LGFLEN`, 4 — log2 of port-A FIFO depth (16 entries); legal range 1..8.
- `i_clk`  in  1  — system clock; all state changes on rising edge.
- `i_reset_n`  in  1  — asynchronous, active-low reset.
- `i_a_stb`  in  1  — port A byte valid, one-cycle strobe (from `rxuart`).
- `i_a_data`  in  8  — port A byte.
- `i_b_stb`  in  1  — port B request; held until accepted.
- `i_b_data`  in  8  — port B byte; must be stable while `i_b_stb` is high and `o_b_busy` is high.
- `o_b_busy`  out  1  — port B holding register full; a B byte is accepted when `i_b_stb && !o_b_busy`.
- `i_ovf_clr`  in  1  — clears `o_a_overflow`.
- `o_a_overflow`  out  1  — sticky: a port A byte was dropped because the FIFO was full.
- `o_a_fill`  out  LGFLEN+1  — current port A FIFO occupancy.
- `o_tx_stb`  out  1  — byte request to `txuart`.
- `o_tx_data`  out  8  — byte to `txuart`; stable while `o_tx_stb` is high.
- `i_tx_busy`  in  1  — `txuart` busy; a byte is taken on the cycle where `o_tx_stb && !i_tx_busy`.

## Operation
- **Reset values.** Under reset (`i_reset_n` low) every output is 0: `o_tx_stb`, `o_tx_data`, `o_b_busy`, `o_a_overflow`, `o_a_fill`.
  - FIFO pointers are cleared, the B holding register is emptied, and the FSM goes to IDLE.
  - The round-robin pointer is reset to "B last", so A wins the first tie.
- **Port A FIFO.** Circular buffer of 2^LGFLEN entries. Read and write pointers are LGFLEN+1 bits wide and wrap modulo 2^(LGFLEN+1).
  - Full when the pointers differ only in the MSB; `o_a_fill` = write pointer − read pointer.
  - An `i_a_stb` while full, with no read in the same cycle, drops the byte and sets `o_a_overflow`.
  - A write and a read in the same cycle while full are both accepted: no drop, and `o_a_fill` is unchanged.
  - If `i_ovf_clr` and a new overflow occur in the same cycle, the overflow wins.
- **Port B.** A single 8-bit holding register. `o_b_busy` goes high the cycle after acceptance and drops the cycle after the held byte is granted to the transmitter.
- **FSM states.**
  - IDLE: `o_tx_stb`=0. If A is non-empty or the B register is full, select a winner, load `o_tx_data`, pop/empty the winning source, and go to SEND.
  - SEND: `o_tx_stb`=1. When `!i_tx_busy`, the byte is taken; drop `o_tx_stb` and return to IDLE. Otherwise hold.
- **Source availability.** A byte that arrives on a source in the same cycle as an IDLE decision is not visible until the next cycle. There is no bypass.

## Timing
- Port A: a strobe at cycle n increments `o_a_fill` at n+1. With IDLE and `i_tx_busy`=0, `o_tx_stb` rises at n+2 and is taken at n+2.
- Port B: accept at n; `o_b_busy`=1 at n+1; `o_tx_stb`=1 at n+2; `o_b_busy`=0 at n+2.
- Minimum 2 cycles per byte (SEND, IDLE). This is far below any UART character time, so the arbiter is never the throughput limit.
- Asynchronous reset mid-SEND drops `o_tx_stb` immediately. A frame already inside `txuart` is `txuart`'s concern.

## Configuration
- **`UART_TX_ARB_RR_EN` defined:** round-robin. When both sources are pending, grant the source not granted last. The pointer updates only on a grant.
- **`UART_TX_ARB_RR_EN` undefined:** fixed priority, A always wins. Port B can starve under continuous echo traffic; this is accepted for echo-critical builds. The pointer logic is absent.

## Test plan
- **Reset.** Pulse `i_reset_n` low mid-SEND with `o_tx_data`=8'h41 → all outputs 0 within the same cycle; after release, `o_a_fill`=0 and `o_b_busy`=0.
- **A latency.** Single A strobe 8'h55 with `i_tx_busy`=0 → `o_tx_stb` high at n+2 with 8'h55 for exactly 1 cycle; `o_a_fill` goes 1 then 0.
- **FIFO overflow.** Hold `i_tx_busy`=1 and send 17 A bytes 8'h00..8'h10 with LGFLEN=4 → `o_a_fill`=16, `o_a_overflow`=1, 8'h10 dropped.
  - Then release busy → 8'h00..8'h0F emerge in order.
  - `i_ovf_clr` then clears the flag.
- **Full plus simultaneous read/write.** FIFO full, `i_tx_busy`=0, A strobe 8'hAA on the pop cycle → no overflow, `o_a_fill` stays 16, 8'hAA delivered last.
- **Arbitration.** A FIFO holds 8'h01, 8'h02 and B holds 8'hB0 at the same time.
  - RR build → 8'h01, 8'hB0, 8'h02.
  - Without `UART_TX_ARB_RR_EN` → 8'h01, 8'h02, 8'hB0.
- **Hold under busy.** B byte 8'h7E with `i_tx_busy`=1 for 100 cycles → `o_tx_stb` and `o_tx_data`=8'h7E stable throughout; taken on the first cycle busy is low.
